// File: rtl/ms_es_param_mul.sv
// Stochastic-style unary multiplier: each operand is expanded into STRIDE unary
// lanes per cycle, lane AND-products are popcounted and accumulated into the exact product.
module ms_es_param_mul #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned STRIDE     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   bin_data_in,
    output logic                               busy,
    output logic                               done,
    output logic [DATA_WIDTH*NUM_INPUTS-1:0]   bin_data_out
);

    localparam int unsigned RES_W = DATA_WIDTH * NUM_INPUTS;
    localparam int unsigned LANES = STRIDE ** NUM_INPUTS;
    localparam int unsigned LOG_S = (STRIDE == 4) ? 2 : ((STRIDE == 2) ? 1 : 0);
    localparam int unsigned CW    = DATA_WIDTH - LOG_S;
    // A zero-width counter is kept as one bit that never leaves zero.
    localparam int unsigned CWR   = (CW == 0) ? 1 : CW;
    localparam logic [CWR-1:0] CMAX = CWR'((2 ** CW) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     opv [NUM_INPUTS];
    logic [CWR-1:0]            cnt [NUM_INPUTS];
    logic [RES_W-1:0]          acc;
    logic [NUM_INPUTS*STRIDE-1:0] lanes;
    logic [NUM_INPUTS-1:0]     en;
    logic [RES_W-1:0]          pop;
    logic                      last;
    logic                      any_zero;

    // Unary lane k of operand i is set while its position is below the operand value.
    always_comb begin
        lanes = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            for (int k = 0; k < STRIDE; k++) begin
                lanes[i*STRIDE + k] = ((32'(cnt[i]) * STRIDE) + 32'(k)) < 32'(opv[i]);
            end
        end
    end

    // Ripple enables: counter i advances when all lower counters wrap.
    always_comb begin
        en    = '0;
        en[0] = 1'b1;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            en[i] = en[i-1] && (cnt[i-1] == CMAX);
        end
        last = en[NUM_INPUTS-1] &&
               (((32'(cnt[NUM_INPUTS-1]) + 32'd1) * STRIDE) >= 32'(opv[NUM_INPUTS-1]));
    end

    // Popcount over every combination of one lane per operand.
    always_comb begin
        int unsigned idx;
        logic        b;
        idx = 0;
        b   = 1'b0;
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = l;
            b   = 1'b1;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                b   = b & lanes[i*STRIDE + (idx % STRIDE)];
                idx = idx / STRIDE;
            end
            pop = pop + RES_W'(b);
        end
    end

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bin_data_in[i*DATA_WIDTH +: DATA_WIDTH] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    // Control FSM with registered status and result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bin_data_out <= '0;
            acc          <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                opv[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            opv[i] <= bin_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                            cnt[i] <= '0;
                        end
                        acc  <= '0;
                        busy <= 1'b1;
                        if (any_zero) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            bin_data_out <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (en[i]) begin
                            cnt[i] <= (cnt[i] == CMAX) ? '0 : cnt[i] + CWR'(1);
                        end
                    end
                    acc <= acc + pop;
                    if (last) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        bin_data_out <= acc + pop;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_es_param_mul.sv
// Bench for ms_es_param_mul: four parameter sets checked every cycle against a
// cycle-count/product model, plus directed literal checks.
module tb_ms_es_param_mul;

    logic        clk;
    logic        rst;
    logic        start_v [4];
    logic [31:0] din_v   [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic [31:0] out_v   [4];

    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [7:0]  out0;
    logic [11:0] out1;
    logic [7:0]  out2;
    logic [5:0]  out3;

    int n_chk = 0;
    int n_fail = 0;

    ms_es_param_mul #(.DATA_WIDTH(4), .NUM_INPUTS(2), .STRIDE(4)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bin_data_in(din_v[0][7:0]),
        .busy(busy0), .done(done0), .bin_data_out(out0));
    ms_es_param_mul #(.DATA_WIDTH(4), .NUM_INPUTS(3), .STRIDE(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bin_data_in(din_v[1][11:0]),
        .busy(busy1), .done(done1), .bin_data_out(out1));
    ms_es_param_mul #(.DATA_WIDTH(2), .NUM_INPUTS(4), .STRIDE(4)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bin_data_in(din_v[2][7:0]),
        .busy(busy2), .done(done2), .bin_data_out(out2));
    ms_es_param_mul #(.DATA_WIDTH(3), .NUM_INPUTS(2), .STRIDE(1)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .bin_data_in(din_v[3][5:0]),
        .busy(busy3), .done(done3), .bin_data_out(out3));

    assign busy_v[0] = busy0;
    assign busy_v[1] = busy1;
    assign busy_v[2] = busy2;
    assign busy_v[3] = busy3;
    assign done_v[0] = done0;
    assign done_v[1] = done1;
    assign done_v[2] = done2;
    assign done_v[3] = done3;
    assign out_v[0]  = 32'(out0);
    assign out_v[1]  = 32'(out1);
    assign out_v[2]  = 32'(out2);
    assign out_v[3]  = 32'(out3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_w(input int j);
        case (j)
            0: return 4;
            1: return 4;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int p_n(input int j);
        case (j)
            0: return 2;
            1: return 3;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int p_s(input int j);
        case (j)
            0: return 4;
            1: return 2;
            2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int opnd(input int j, input logic [31:0] d, input int i);
        return int'((d >> (i * p_w(j))) & ((32'd1 << p_w(j)) - 32'd1));
    endfunction

    function automatic int f_prod(input int j, input logic [31:0] d);
        int p;
        p = 1;
        for (int i = 0; i < p_n(j); i++) p = p * opnd(j, d, i);
        return p;
    endfunction

    // Expected RUN length; 0 means the zero-operand shortcut.
    function automatic int f_len(input int j, input logic [31:0] d);
        int len;
        int vl;
        if (f_prod(j, d) == 0) return 0;
        len = 1;
        for (int i = 0; i < p_n(j) - 1; i++) len = len * ((1 << p_w(j)) / p_s(j));
        vl = opnd(j, d, p_n(j) - 1);
        return len * ((vl + p_s(j) - 1) / p_s(j));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: busy/done/result as a function of accepted starts.
    logic m_busy [4] = '{default: 1'b0};
    logic m_done [4] = '{default: 1'b0};
    int   m_left [4] = '{default: 0};
    int   m_prod [4] = '{default: 0};
    int   m_out  [4] = '{default: 0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 4; j++) begin
                m_busy[j] <= 1'b0;
                m_done[j] <= 1'b0;
                m_left[j] <= 0;
                m_out[j]  <= 0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (m_done[j]) begin
                    m_done[j] <= 1'b0;
                    m_busy[j] <= 1'b0;
                end else if (m_busy[j]) begin
                    if (m_left[j] == 1) begin
                        m_done[j] <= 1'b1;
                        m_out[j]  <= m_prod[j];
                    end
                    m_left[j] <= m_left[j] - 1;
                end else if (start_v[j]) begin
                    m_busy[j] <= 1'b1;
                    m_prod[j] <= f_prod(j, din_v[j]);
                    if (f_len(j, din_v[j]) == 0) begin
                        m_done[j] <= 1'b1;
                        m_out[j]  <= 0;
                    end else begin
                        m_left[j] <= f_len(j, din_v[j]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("busy[%0d]", j), longint'(busy_v[j]), longint'(m_busy[j]));
            chk($sformatf("done[%0d]", j), longint'(done_v[j]), longint'(m_done[j]));
            chk($sformatf("out[%0d]", j), longint'(out_v[j]), longint'(m_out[j]));
        end
    end

    // Pulse start now (sampled on the next edge), wait for done, then let the DUT reach IDLE.
    task automatic go(input int j, input logic [31:0] d, output int lat, output int bcnt);
        int n;
        int b;
        start_v[j] = 1'b1;
        din_v[j]   = d;
        @(posedge clk); #1;
        start_v[j] = 1'b0;
        n = 0;
        b = int'(busy_v[j]);
        while (!done_v[j] && n < 6000) begin
            @(posedge clk); #1;
            n++;
            b += int'(busy_v[j]);
        end
        if (!done_v[j]) chk($sformatf("timeout[%0d]", j), 0, 1);
        lat  = n;
        bcnt = b;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int bc;
        int n;
        int dp;
        logic [31:0] d;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            start_v[j] = 1'b0;
            din_v[j]   = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_done", longint'(done0), 0);
        chk("reset_out", longint'(out0), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        go(0, 32'h35, lat, bc);
        chk("5x3_lat", lat, 4);
        chk("5x3_out", longint'(out0), 15);

        go(0, 32'hFF, lat, bc);
        chk("15x15_lat", lat, 16);
        chk("15x15_out", longint'(out0), 225);

        go(0, 32'h90, lat, bc);
        chk("0x9_lat", lat, 0);
        chk("0x9_out", longint'(out0), 0);

        go(1, 32'h357, lat, bc);
        chk("7x5x3_lat", lat, 128);
        chk("7x5x3_out", longint'(out1), 105);
        chk("7x5x3_busy", bc, 129);

        // Start pulses and operand churn during RUN must not disturb the product.
        start_v[0] = 1'b1;
        din_v[0]   = 32'h35;
        @(posedge clk); #1;
        n = 0;
        while (!done0 && n < 100) begin
            start_v[0] = 1'b1;
            din_v[0]   = $urandom;
            @(posedge clk); #1;
            n++;
        end
        start_v[0] = 1'b0;
        dp = int'(done0);
        repeat (4) begin
            @(posedge clk); #1;
            dp += int'(done0);
        end
        chk("ignore_lat", n, 4);
        chk("ignore_out", longint'(out0), 15);
        chk("ignore_pulses", dp, 1);

        // Asynchronous reset in the middle of a long run.
        start_v[0] = 1'b1;
        din_v[0]   = 32'hFF;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_busy", longint'(busy0), 0);
        chk("arst_done", longint'(done0), 0);
        chk("arst_out", longint'(out0), 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst_hold_done", longint'(done0), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        go(0, 32'h32, lat, bc);
        chk("2x3_lat", lat, 4);
        chk("2x3_out", longint'(out0), 6);

        // Random sweep across every instantiated parameter set.
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 6; r++) begin
                d = $urandom;
                go(j, d, lat, bc);
                chk($sformatf("sweep_lat[%0d]", j), lat, f_len(j, d));
                chk($sformatf("sweep_out[%0d]", j), longint'(out_v[j]), f_prod(j, d));
                chk($sformatf("sweep_busy[%0d]", j), bc, lat + 1);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
